// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen.
// Carries the pixel coordinates, draw flag, syncs, strobes and frame counter.
// The master modport drives the bundle; the slave modport is for consumers.
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        output DrawX,
        output DrawY,
        output blank,
        output hs,
        output vs,
        output line_start,
        output frame_start,
        output frame_count
    );

    modport slave (
        input DrawX,
        input DrawY,
        input blank,
        input hs,
        input vs,
        input line_start,
        input frame_start,
        input frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 640x480 @ 60 Hz pixel clock domain.
// Ports: vga_clk (pixel clock), reset_n (async active-low reset),
//   vga (master): DrawX/DrawY counters, blank (1 = draw), hs/vs
//   (active-low, delayed by SYNC_DELAY), line_start/frame_start
//   strobes and an 8-bit wrapping frame_count.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input logic              vga_clk,
    input logic              reset_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       h_wrap;
    logic       blank_q, blank_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic       hs_raw_q, hs_raw_d;
    logic       vs_raw_q, vs_raw_d;
    logic [7:0] fcnt_q, fcnt_d;

    // Every decoded flag is taken from the next-state counters and
    // registered, so it is coherent with DrawX/DrawY in the same cycle.
    always_comb begin
        h_wrap = (x_q == H_LAST);
        x_d    = h_wrap ? 10'd0 : x_q + 10'd1;
        y_d    = y_q;
        if (h_wrap) begin
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end
        blank_d  = (x_d < H_VIS) && (y_d < V_VIS);
        ls_d     = (x_d == 10'd0);
        fs_d     = ls_d && (y_d == 10'd0);
        hs_raw_d = !((x_d >= HS_BEG) && (x_d < HS_END));
        vs_raw_d = !((y_d >= VS_BEG) && (y_d < VS_END));
        fcnt_d   = fs_d ? fcnt_q + 8'd1 : fcnt_q;
    end

    // Reset parks the counters on the last pixel of the frame so the
    // first edge lands on (0,0) and counts as a frame start.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= H_LAST;
            y_q      <= V_LAST;
            blank_q  <= 1'b0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
            hs_raw_q <= 1'b1;
            vs_raw_q <= 1'b1;
            fcnt_q   <= 8'hFF;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            blank_q  <= blank_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
            hs_raw_q <= hs_raw_d;
            vs_raw_q <= vs_raw_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign vga.DrawX       = x_q;
    assign vga.DrawY       = y_q;
    assign vga.blank       = blank_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;
    assign vga.frame_count = fcnt_q;

    // Syncs are delayed to line up with the sprite stages' registered
    // colour output; stages reset to the inactive (high) level.
    generate
        if (SYNC_DELAY == 0) begin : g_nodly
            assign vga.hs = hs_raw_q;
            assign vga.vs = vs_raw_q;
        end else if (SYNC_DELAY == 1) begin : g_dly1
            logic hs_dly_q;
            logic vs_dly_q;
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_dly_q <= 1'b1;
                    vs_dly_q <= 1'b1;
                end else begin
                    hs_dly_q <= hs_raw_q;
                    vs_dly_q <= vs_raw_q;
                end
            end
            assign vga.hs = hs_dly_q;
            assign vga.vs = vs_dly_q;
        end else begin : g_dlyn
            logic [SYNC_DELAY-1:0] hs_sr_q;
            logic [SYNC_DELAY-1:0] vs_sr_q;
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_sr_q <= '1;
                    vs_sr_q <= '1;
                end else begin
                    hs_sr_q <= {hs_sr_q[SYNC_DELAY-2:0], hs_raw_q};
                    vs_sr_q <= {vs_sr_q[SYNC_DELAY-2:0], vs_raw_q};
                end
            end
            assign vga.hs = hs_sr_q[SYNC_DELAY-1];
            assign vga.vs = vs_sr_q[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: small rasters with several
// sync delays plus a default-sized instance, against an arithmetic model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HSW = 3;
    localparam int HB = 2;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VSW = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FR = HT * VT;

    typedef struct {
        int x;
        int y;
        bit b;
        bit h;
        bit v;
        bit ls;
        bit fs;
        int fc;
    } exp_t;

    typedef struct {
        int n;
        int x;
        int y;
        bit b;
        bit h;
        bit v;
        bit ls;
        bit fs;
        int fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    vec_t tbl[15];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    vga_timing_gen_if if0 ();
    vga_timing_gen_if if1 ();
    vga_timing_gen_if if3 ();
    vga_timing_gen_if ifd ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_DELAY(0)
    ) u_dut0 (.vga_clk(clk), .reset_n(rst_n), .vga(if0));

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_DELAY(1)
    ) u_dut1 (.vga_clk(clk), .reset_n(rst_n), .vga(if1));

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_DELAY(3)
    ) u_dut3 (.vga_clk(clk), .reset_n(rst_n), .vga(if3));

    vga_timing_gen u_dutd (.vga_clk(clk), .reset_n(rst_n), .vga(ifd));

    // Expected outputs n clocks after reset release, from raster arithmetic.
    function automatic exp_t model(input int n, input int ha, input int hf,
                                   input int hsw, input int hb, input int va,
                                   input int vf, input int vsw, input int vb,
                                   input int d);
        exp_t e;
        int ht, vt, m, xm, ym;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        e.x  = n % ht;
        e.y  = (n / ht) % vt;
        e.b  = (e.x < ha) && (e.y < va);
        e.ls = (e.x == 0);
        e.fs = e.ls && (e.y == 0);
        e.fc = (n / (ht * vt)) % 256;
        if (n - d < 0) begin
            e.h = 1'b1;
            e.v = 1'b1;
        end else begin
            m  = n - d;
            xm = m % ht;
            ym = (m / ht) % vt;
            e.h = !((xm >= ha + hf) && (xm < ha + hf + hsw));
            e.v = !((ym >= va + vf) && (ym < va + vf + vsw));
        end
        return e;
    endfunction

    function automatic exp_t rst_exp(input int ht, input int vt);
        exp_t e;
        e.x = ht - 1;
        e.y = vt - 1;
        e.b = 1'b0;
        e.h = 1'b1;
        e.v = 1'b1;
        e.ls = 1'b0;
        e.fs = 1'b0;
        e.fc = 255;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)",
                     name, act, exp, cyc - 1, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input logic [9:0] x,
                           input logic [9:0] y, input logic b,
                           input logic h, input logic v, input logic ls,
                           input logic fs, input logic [7:0] fc,
                           input exp_t e);
        chk({tag, ".DrawX"}, int'(x), e.x);
        chk({tag, ".DrawY"}, int'(y), e.y);
        chk({tag, ".blank"}, int'(b), int'(e.b));
        chk({tag, ".hs"}, int'(h), int'(e.h));
        chk({tag, ".vs"}, int'(v), int'(e.v));
        chk({tag, ".line_start"}, int'(ls), int'(e.ls));
        chk({tag, ".frame_start"}, int'(fs), int'(e.fs));
        chk({tag, ".frame_count"}, int'(fc), e.fc);
    endtask

    task automatic check_reset_all();
        cmp_all("rst0", if0.DrawX, if0.DrawY, if0.blank, if0.hs, if0.vs,
                if0.line_start, if0.frame_start, if0.frame_count,
                rst_exp(HT, VT));
        cmp_all("rst1", if1.DrawX, if1.DrawY, if1.blank, if1.hs, if1.vs,
                if1.line_start, if1.frame_start, if1.frame_count,
                rst_exp(HT, VT));
        cmp_all("rst3", if3.DrawX, if3.DrawY, if3.blank, if3.hs, if3.vs,
                if3.line_start, if3.frame_start, if3.frame_count,
                rst_exp(HT, VT));
        cmp_all("rstd", ifd.DrawX, ifd.DrawY, ifd.blank, ifd.hs, ifd.vs,
                ifd.line_start, ifd.frame_start, ifd.frame_count,
                rst_exp(800, 525));
    endtask

    // Continuous scoreboard: every running cycle of every instance.
    always @(negedge clk) begin
        if (rst_n && cyc > 0) begin
            cmp_all("d0", if0.DrawX, if0.DrawY, if0.blank, if0.hs, if0.vs,
                    if0.line_start, if0.frame_start, if0.frame_count,
                    model(cyc - 1, HA, HF, HSW, HB, VA, VF, VSW, VB, 0));
            cmp_all("d1", if1.DrawX, if1.DrawY, if1.blank, if1.hs, if1.vs,
                    if1.line_start, if1.frame_start, if1.frame_count,
                    model(cyc - 1, HA, HF, HSW, HB, VA, VF, VSW, VB, 1));
            cmp_all("d3", if3.DrawX, if3.DrawY, if3.blank, if3.hs, if3.vs,
                    if3.line_start, if3.frame_start, if3.frame_count,
                    model(cyc - 1, HA, HF, HSW, HB, VA, VF, VSW, VB, 3));
            cmp_all("dd", ifd.DrawX, ifd.DrawY, ifd.blank, ifd.hs, ifd.vs,
                    ifd.line_start, ifd.frame_start, ifd.frame_count,
                    model(cyc - 1, 640, 16, 96, 48, 480, 10, 2, 33, 1));
        end
    end

    task automatic release_reset(input int hold);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int cb, ch, cv, cl, cf, guard;
        bit found;

        // n, x, y, blank, hs, vs, line_start, frame_start, frame_count
        tbl[0]  = '{0,   0,  0,  1, 1, 1, 1, 1, 0};
        tbl[1]  = '{7,   7,  0,  1, 1, 1, 0, 0, 0};
        tbl[2]  = '{8,   8,  0,  0, 1, 1, 0, 0, 0};
        tbl[3]  = '{10,  10, 0,  0, 1, 1, 0, 0, 0};
        tbl[4]  = '{11,  11, 0,  0, 0, 1, 0, 0, 0};
        tbl[5]  = '{13,  13, 0,  0, 0, 1, 0, 0, 0};
        tbl[6]  = '{14,  14, 0,  0, 1, 1, 0, 0, 0};
        tbl[7]  = '{15,  0,  1,  1, 1, 1, 1, 0, 0};
        tbl[8]  = '{90,  0,  6,  0, 1, 1, 1, 0, 0};
        tbl[9]  = '{105, 0,  7,  0, 1, 1, 1, 0, 0};
        tbl[10] = '{106, 1,  7,  0, 1, 0, 0, 0, 0};
        tbl[11] = '{135, 0,  9,  0, 1, 0, 1, 0, 0};
        tbl[12] = '{136, 1,  9,  0, 1, 1, 0, 0, 0};
        tbl[13] = '{164, 14, 10, 0, 1, 1, 0, 0, 0};
        tbl[14] = '{165, 0,  0,  1, 1, 1, 1, 1, 1};

        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_reset_all();
        end
        #1 rst_n = 1'b1;

        // Hand-computed vectors for the SYNC_DELAY=1 small raster.
        for (int i = 0; i < 15; i++) begin
            do @(negedge clk); while (cyc - 1 < tbl[i].n);
            chk("tbl.n", cyc - 1, tbl[i].n);
            cmp_all($sformatf("tbl%0d", i), if1.DrawX, if1.DrawY,
                    if1.blank, if1.hs, if1.vs, if1.line_start,
                    if1.frame_start, if1.frame_count,
                    '{tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].h, tbl[i].v,
                      tbl[i].ls, tbl[i].fs, tbl[i].fc});
        end

        // One full-size visible line: 640 draw clocks, 96 hsync clocks.
        found = 1'b0;
        guard = 0;
        while (!found && guard < 1700) begin
            @(negedge clk);
            guard++;
            found = ifd.line_start && (ifd.DrawY < 10'd480);
        end
        chk("full_line.found", int'(found), 1);
        cb = 0; ch = 0; cl = 0;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) @(negedge clk);
            cb += int'(ifd.blank);
            ch += int'(!ifd.hs);
            cl += int'(ifd.line_start);
        end
        chk("full_line.blank_cnt", cb, 640);
        chk("full_line.hs_low_cnt", ch, 96);
        chk("full_line.line_start_cnt", cl, 1);

        // One small frame: totals over exactly one frame period.
        found = 1'b0;
        guard = 0;
        while (!found && guard < 2 * FR) begin
            @(negedge clk);
            guard++;
            found = if1.frame_start;
        end
        chk("frame.found", int'(found), 1);
        cb = 0; ch = 0; cv = 0; cl = 0; cf = 0;
        for (int i = 0; i < FR; i++) begin
            if (i > 0) @(negedge clk);
            cb += int'(if1.blank);
            ch += int'(!if1.hs);
            cv += int'(!if1.vs);
            cl += int'(if1.line_start);
            cf += int'(if1.frame_start);
        end
        chk("frame.blank_cnt", cb, HA * VA);
        chk("frame.hs_low_cnt", ch, HSW * VT);
        chk("frame.vs_low_cnt", cv, VSW * HT);
        chk("frame.line_start_cnt", cl, VT);
        chk("frame.frame_start_cnt", cf, 1);

        // Run past 257 frames so frame_count wraps 255 -> 0 -> 1.
        while (cyc - 1 < 257 * FR + 3) @(negedge clk);
        chk("wrap.frame_count", int'(if1.frame_count), 1);

        // Mid-frame reset between edges at (5,3) of the small raster.
        found = 1'b0;
        guard = 0;
        while (!found && guard < 2 * FR) begin
            @(negedge clk);
            guard++;
            found = (if1.DrawX == 10'd5) && (if1.DrawY == 10'd3);
        end
        chk("midrst.found", int'(found), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_all();
        release_reset(2);
        @(negedge clk);
        chk("restart.DrawX", int'(if1.DrawX), 0);
        chk("restart.DrawY", int'(if1.DrawY), 0);
        chk("restart.frame_start", int'(if1.frame_start), 1);
        chk("restart.frame_count", int'(ifd.frame_count), 0);

        // Randomly timed resets; the scoreboard checks each restart.
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(20, 600)) @(negedge clk);
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1 check_reset_all();
            release_reset($urandom_range(1, 4));
        end
        repeat (2 * FR) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz display path. It runs on the 25 MHz pixel clock and produces the pixel coordinates (`DrawX`, `DrawY`) and visible-area flag (`blank`) consumed by every sprite-drawing stage. It also produces the VGA sync outputs, delayed so they line up with the sprite stages' one-cycle registered colour output. Frame and line strobes plus a free-running frame counter are provided for animation and score-update logic.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_DELAY`, 1, pipeline delay applied to `hs`/`vs`, range 0..4
- `vga_clk` in 1: pixel clock, all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `DrawX` out 10: current column, 0..H_TOTAL-1.
- `DrawY` out 10: current line, 0..V_TOTAL-1.
- `blank` out 1: 1 when (DrawX, DrawY) is in the visible area. Despite the name, 1 means draw, matching the consumers.
- `hs` out 1: horizontal sync, active-low, delayed by SYNC_DELAY.
- `vs` out 1: vertical sync, active-low, delayed by SYNC_DELAY.
- `line_start` out 1: one-cycle pulse while DrawX==0.
- `frame_start` out 1: one-cycle pulse while DrawX==0 and DrawY==0.
- `frame_count` out 8: number of completed frames, wraps modulo 256.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Horizontal counter: increments every clock; at H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only on a horizontal wrap; at V_TOTAL-1 with a horizontal wrap it wraps to 0.
- `DrawX`/`DrawY` are the counter registers themselves.
- `blank`, `line_start`, `frame_start` and the undelayed syncs are registers, computed from the next-state counter values, so they are coherent with `DrawX`/`DrawY` in the same cycle (no combinational decode on outputs).
- `blank` = (x < H_ACTIVE) and (y < V_ACTIVE).
- Undelayed hsync is low for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656, 752).
- Undelayed vsync is low for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. lines 490..491, for the full 800 clocks of each line.
- Sync delay: `hs`/`vs` pass through a SYNC_DELAY-deep shift register. With SYNC_DELAY=0 they equal the undelayed registers.
- `frame_count` increments on the same edge the counters enter (0,0). It wraps 255→0.
- No enable or stall input: the raster never pauses.

## Timing
- Reset values (async, while `reset_n`=0):
  - `DrawX`=H_TOTAL-1 (799), `DrawY`=V_TOTAL-1 (524).
  - `blank`=0, `line_start`=0, `frame_start`=0.
  - All hs/vs shift stages=1, so `hs`=1, `vs`=1.
  - `frame_count`=8'hFF.
- First rising edge after `reset_n` deasserts:
  - `DrawX`=0, `DrawY`=0.
  - `blank`=1, `line_start`=1, `frame_start`=1.
  - `frame_count`=0.
- Line period 800 clocks; frame period 420000 clocks; 307200 clocks per frame with `blank`=1.
- `hs` falls exactly SYNC_DELAY clocks after the cycle with DrawX=656. It stays low 96 clocks.
- `vs` falls SYNC_DELAY clocks after the cycle with (DrawX, DrawY)=(0, 490). It stays low 1600 clocks.
- Reset asserted mid-frame: all outputs go to reset values immediately, without waiting for a clock. Restart is identical to power-up. No partial line is emitted.
- Simultaneous horizontal and vertical wrap at (799,524): on the single edge into (0,0), `frame_start` and `line_start` rise and `frame_count` increments.

## Test plan
- Reset release:
  - Hold `reset_n`=0 for 5 clocks and check (799, 524), blank=0, hs=vs=1.
  - Release and check the first edge gives (0,0), frame_start=1, line_start=1, blank=1, frame_count=0.
- Horizontal timing:
  - Over one line, `blank`=1 for exactly 640 clocks (DrawY<480).
  - With SYNC_DELAY=1, `hs` is low from the cycle after DrawX=656 through the cycle after DrawX=751 (96 clocks).
  - `line_start` pulses once per 800 clocks.
- Vertical timing:
  - Over one frame, `vs` low for 1600 consecutive clocks starting one clock after (0,490).
  - `blank` high count = 307200.
  - `frame_start` interval = 420000 clocks.
- Frame counter wrap: run 257 frames; `frame_count` sequence 0..255, 0; each increment coincides with `frame_start`.
- Mid-frame reset: assert `reset_n`=0 at (300, 200) between clock edges. Outputs return to reset values before the next edge; after release, the timing matches the reset-release case.
- SYNC_DELAY=0 and SYNC_DELAY=3 builds: `hs` falls in the cycle of DrawX=656 and DrawX=656+3 respectively. Widths unchanged.
